// File: rtl/mem_connector_arb.sv
// SPI SRAM connector: per-channel ownership FSM that hands each SRAM between its FPGA engine
// and the RPi master, only across an idle guard window, with at most one RPi-owned channel.
module mem_connector_arb #(
    parameter int N_CH         = 4,
    parameter int SEL_W        = $clog2(N_CH),
    parameter int GUARD_CYCLES = 4,
    parameter int SYNC_STAGES  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rpi_en,
    input  logic [SEL_W-1:0]  i_rpi_sel,
    input  logic              i_rpi_cs_n,
    input  logic              i_rpi_sclk,
    input  logic              i_rpi_mosi,
    output logic              o_rpi_miso,
    input  logic [N_CH-1:0]   i_fpga_cs_n,
    input  logic [N_CH-1:0]   i_fpga_sclk,
    input  logic [N_CH-1:0]   i_fpga_mosi,
    output logic [N_CH-1:0]   o_fpga_miso,
    output logic [N_CH-1:0]   o_fpga_gnt,
    output logic [N_CH-1:0]   o_mem_cs_n,
    output logic [N_CH-1:0]   o_mem_sclk,
    output logic [N_CH-1:0]   o_mem_mosi,
    input  logic [N_CH-1:0]   i_mem_miso,
    output logic [N_CH-1:0]   o_owner_rpi,
    output logic [N_CH-1:0]   o_switch_busy
);

    // state    | meaning
    // FPGA_OWN | SRAM wired to its FPGA engine
    // DRAIN_F  | RPi wants the channel; waiting for idle guard and no other RPi owner
    // RPI_OWN  | SRAM wired to the RPi pins
    // DRAIN_R  | RPi released the channel; waiting for RPi CS idle guard
    typedef enum logic [1:0] {
        FPGA_OWN = 2'd0,
        DRAIN_F  = 2'd1,
        RPI_OWN  = 2'd2,
        DRAIN_R  = 2'd3
    } state_t;

    localparam int              CNT_W    = $clog2(GUARD_CYCLES + 1);
    localparam logic [CNT_W-1:0] GUARD_TC = CNT_W'(GUARD_CYCLES);

    logic [SYNC_STAGES-1:0]            r_en_sync;
    logic [SYNC_STAGES-1:0]            r_cs_sync;
    logic [SYNC_STAGES-1:0][SEL_W-1:0] r_sel_sync;

    state_t           r_state [N_CH];
    logic [CNT_W-1:0] r_cnt   [N_CH];

    logic             w_rpi_en_s;
    logic             w_rpi_cs_n_s;
    logic [SEL_W-1:0] w_rpi_sel_s;
    logic [N_CH-1:0]  w_tgt;
    logic             w_rpi_busy;
    logic [CNT_W-1:0] w_cnt_f_nxt [N_CH];
    logic [CNT_W-1:0] w_cnt_r_nxt [N_CH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_en_sync  <= '0;
            r_cs_sync  <= '1;
            r_sel_sync <= '0;
        end else begin
            r_en_sync     <= {r_en_sync[SYNC_STAGES-2:0], i_rpi_en};
            r_cs_sync     <= {r_cs_sync[SYNC_STAGES-2:0], i_rpi_cs_n};
            r_sel_sync[0] <= i_rpi_sel;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sel_sync[k] <= r_sel_sync[k-1];
            end
        end
    end

    assign w_rpi_en_s   = r_en_sync[SYNC_STAGES-1];
    assign w_rpi_cs_n_s = r_cs_sync[SYNC_STAGES-1];
    assign w_rpi_sel_s  = r_sel_sync[SYNC_STAGES-1];

    // Guard counters saturate at the terminal count and restart whenever a CS is active
    always_comb begin
        w_tgt      = '0;
        w_rpi_busy = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            w_tgt[i] = w_rpi_en_s && (w_rpi_sel_s == SEL_W'(i));
            if (r_state[i] == RPI_OWN || r_state[i] == DRAIN_R) begin
                w_rpi_busy = 1'b1;
            end
            w_cnt_f_nxt[i] = '0;
            w_cnt_r_nxt[i] = '0;
            if (w_rpi_cs_n_s) begin
                w_cnt_r_nxt[i] = (r_cnt[i] == GUARD_TC) ? GUARD_TC : r_cnt[i] + CNT_W'(1);
                if (i_fpga_cs_n[i]) begin
                    w_cnt_f_nxt[i] = w_cnt_r_nxt[i];
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= FPGA_OWN;
                r_cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                case (r_state[i])
                    FPGA_OWN: begin
                        if (w_tgt[i]) begin
                            r_state[i] <= DRAIN_F;
                            r_cnt[i]   <= '0;
                        end
                    end
                    DRAIN_F: begin
                        if (!w_tgt[i]) begin
                            r_state[i] <= FPGA_OWN;
                        end else begin
                            r_cnt[i] <= w_cnt_f_nxt[i];
                            // Waits here with a full guard while another channel is still RPi-side
                            if (w_cnt_f_nxt[i] == GUARD_TC && !w_rpi_busy) begin
                                r_state[i] <= RPI_OWN;
                            end
                        end
                    end
                    RPI_OWN: begin
                        if (!w_tgt[i]) begin
                            r_state[i] <= DRAIN_R;
                            r_cnt[i]   <= '0;
                        end
                    end
                    DRAIN_R: begin
                        if (w_tgt[i]) begin
                            r_state[i] <= RPI_OWN;
                        end else begin
                            r_cnt[i] <= w_cnt_r_nxt[i];
                            if (w_cnt_r_nxt[i] == GUARD_TC) begin
                                r_state[i] <= FPGA_OWN;
                            end
                        end
                    end
                    default: begin
                        r_state[i] <= FPGA_OWN;
                        r_cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

    // RPi-side mux uses the raw pins so SPI timing is not delayed by the synchroniser
    always_comb begin
        o_rpi_miso    = 1'b0;
        o_mem_cs_n    = '1;
        o_mem_sclk    = '0;
        o_mem_mosi    = '0;
        o_fpga_gnt    = '0;
        o_owner_rpi   = '0;
        o_switch_busy = '0;
        for (int i = 0; i < N_CH; i++) begin
            case (r_state[i])
                FPGA_OWN: begin
                    o_mem_cs_n[i] = i_fpga_cs_n[i];
                    o_mem_sclk[i] = i_fpga_sclk[i];
                    o_mem_mosi[i] = i_fpga_mosi[i];
                    o_fpga_gnt[i] = !w_tgt[i];
                end
                RPI_OWN: begin
                    o_mem_cs_n[i]  = i_rpi_cs_n;
                    o_mem_sclk[i]  = i_rpi_sclk;
                    o_mem_mosi[i]  = i_rpi_mosi;
                    o_owner_rpi[i] = 1'b1;
                    o_rpi_miso     = o_rpi_miso | i_mem_miso[i];
                end
                default: begin
                    o_switch_busy[i] = 1'b1;
                end
            endcase
        end
    end

    assign o_fpga_miso = i_mem_miso;

endmodule

// File: tb/tb_mem_connector_arb.sv
// Bench for mem_connector_arb: mux vector table with a scoreboard queue, plus timed
// handover sequences on a 4-channel instance and a fast-guard 8-channel instance.
module tb_mem_connector_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       rpi_en, rpi_cs_n, rpi_sclk, rpi_mosi, rpi_miso;
    logic [1:0] rpi_sel;
    logic [3:0] fpga_cs_n, fpga_sclk, fpga_mosi, fpga_miso, fpga_gnt;
    logic [3:0] mem_cs_n, mem_sclk, mem_mosi, mem_miso, owner_rpi, switch_busy;

    logic       e8_en, e8_cs_n, e8_sclk, e8_mosi, e8_rmiso;
    logic [2:0] e8_sel;
    logic [7:0] e8_fcs_n, e8_fsclk, e8_fmosi, e8_fmiso, e8_gnt;
    logic [7:0] e8_mcs_n, e8_msclk, e8_mmosi, e8_mmiso, e8_owner, e8_busy;

    mem_connector_arb #(.N_CH(4), .GUARD_CYCLES(4), .SYNC_STAGES(2)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_rpi_en(rpi_en), .i_rpi_sel(rpi_sel), .i_rpi_cs_n(rpi_cs_n),
        .i_rpi_sclk(rpi_sclk), .i_rpi_mosi(rpi_mosi), .o_rpi_miso(rpi_miso),
        .i_fpga_cs_n(fpga_cs_n), .i_fpga_sclk(fpga_sclk), .i_fpga_mosi(fpga_mosi),
        .o_fpga_miso(fpga_miso), .o_fpga_gnt(fpga_gnt),
        .o_mem_cs_n(mem_cs_n), .o_mem_sclk(mem_sclk), .o_mem_mosi(mem_mosi),
        .i_mem_miso(mem_miso), .o_owner_rpi(owner_rpi), .o_switch_busy(switch_busy)
    );

    mem_connector_arb #(.N_CH(8), .GUARD_CYCLES(1), .SYNC_STAGES(2)) dut8 (
        .i_clk(clk), .i_rst(rst),
        .i_rpi_en(e8_en), .i_rpi_sel(e8_sel), .i_rpi_cs_n(e8_cs_n),
        .i_rpi_sclk(e8_sclk), .i_rpi_mosi(e8_mosi), .o_rpi_miso(e8_rmiso),
        .i_fpga_cs_n(e8_fcs_n), .i_fpga_sclk(e8_fsclk), .i_fpga_mosi(e8_fmosi),
        .o_fpga_miso(e8_fmiso), .o_fpga_gnt(e8_gnt),
        .o_mem_cs_n(e8_mcs_n), .o_mem_sclk(e8_msclk), .o_mem_mosi(e8_mmosi),
        .i_mem_miso(e8_mmiso), .o_owner_rpi(e8_owner), .o_switch_busy(e8_busy)
    );

    typedef struct {
        logic [3:0] f_cs, f_sclk, f_mosi;
        logic       r_cs, r_sclk, r_mosi;
        logic [3:0] m_miso;
    } vec_t;

    typedef struct {
        logic [3:0] cs, sclk, mosi, fmiso;
        logic       rmiso;
    } exp_t;

    vec_t tbl [8];
    exp_t sb_q [$];

    int n_tests   = 0;
    int n_fail    = 0;
    int excl_viol = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic exp_t model(input vec_t v, input logic [3:0] own);
        exp_t e;
        e.cs    = (v.f_cs   & ~own) | ({4{v.r_cs}}   & own);
        e.sclk  = (v.f_sclk & ~own) | ({4{v.r_sclk}} & own);
        e.mosi  = (v.f_mosi & ~own) | ({4{v.r_mosi}} & own);
        e.fmiso = v.m_miso;
        e.rmiso = |(v.m_miso & own);
        return e;
    endfunction

    task automatic idle_pins();
        rpi_cs_n  = 1'b1; rpi_sclk  = 1'b0; rpi_mosi  = 1'b0;
        fpga_cs_n = 4'hF; fpga_sclk = 4'h0; fpga_mosi = 4'h0;
        mem_miso  = 4'h0;
    endtask

    // own is the set of channels known to be RPi-owned; all others are FPGA-owned
    task automatic run_table(input logic [3:0] own);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            fpga_cs_n = tbl[i].f_cs; fpga_sclk = tbl[i].f_sclk; fpga_mosi = tbl[i].f_mosi;
            rpi_cs_n  = tbl[i].r_cs; rpi_sclk  = tbl[i].r_sclk; rpi_mosi  = tbl[i].r_mosi;
            mem_miso  = tbl[i].m_miso;
            sb_q.push_back(model(tbl[i], own));
            #2;
            e = sb_q.pop_front();
            check($sformatf("tbl%0d_own%0h_mem", i, own), {mem_cs_n, mem_sclk, mem_mosi},
                  {e.cs, e.sclk, e.mosi});
            check($sformatf("tbl%0d_own%0h_miso", i, own), {fpga_miso, rpi_miso}, {e.fmiso, e.rmiso});
            check($sformatf("tbl%0d_own%0h_state", i, own), owner_rpi, own);
            cyc(1);
        end
        idle_pins();
    endtask

    always @(negedge clk) begin
        if (!rst && ($countones(owner_rpi) > 1 || $countones(e8_owner) > 1)) begin
            excl_viol++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] exp8;

        tbl[0] = '{4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000};
        tbl[1] = '{4'b0000, 4'b1111, 4'b1111, 1'b0, 1'b1, 1'b1, 4'b1111};
        tbl[2] = '{4'b1010, 4'b0101, 4'b0011, 1'b1, 1'b1, 1'b0, 4'b0100};
        tbl[3] = '{4'b0101, 4'b1010, 4'b1100, 1'b0, 1'b0, 1'b1, 4'b1011};
        tbl[4] = '{4'b1011, 4'b0110, 4'b1001, 1'b0, 1'b1, 1'b0, 4'b0100};
        tbl[5] = '{4'b0100, 4'b1001, 4'b0110, 1'b1, 1'b0, 1'b1, 4'b1011};
        tbl[6] = '{4'b1110, 4'b0001, 4'b1000, 1'b0, 1'b1, 1'b1, 4'b0010};
        tbl[7] = '{4'b0001, 4'b1110, 4'b0111, 1'b1, 1'b0, 1'b0, 4'b1101};

        rst = 1'b1;
        rpi_en = 1'b0; rpi_sel = 2'd0;
        idle_pins();
        e8_en = 1'b0; e8_sel = 3'd0; e8_cs_n = 1'b1; e8_sclk = 1'b0; e8_mosi = 1'b0;
        e8_fcs_n = 8'hFF; e8_fsclk = 8'h00; e8_fmosi = 8'h00; e8_mmiso = 8'h00;

        // Reset values
        fpga_cs_n = 4'b1010; mem_miso = 4'hF;
        #3;
        check("rst_gnt", fpga_gnt, 4'hF);
        check("rst_owner", owner_rpi, 4'h0);
        check("rst_busy", switch_busy, 4'h0);
        check("rst_rpi_miso", rpi_miso, 1'b0);
        check("rst_mem_cs", mem_cs_n, 4'b1010);
        idle_pins();
        cyc(2);
        rst = 1'b0;
        cyc(2);

        run_table(4'b0000);

        // Idle acquisition of channel 2
        rpi_en = 1'b1; rpi_sel = 2'd2;
        cyc(1);
        check("t1_gnt_c1", fpga_gnt[2], 1'b1);
        cyc(2);
        check("t1_gnt_c3", fpga_gnt[2], 1'b0);
        check("t1_busy_c3", switch_busy, 4'b0100);
        check("t1_memcs_c3", mem_cs_n[2], 1'b1);
        cyc(3);
        check("t1_owner_c6", owner_rpi, 4'b0000);
        cyc(1);
        check("t1_owner_c7", owner_rpi, 4'b0100);
        check("t1_gnt_c7", fpga_gnt, 4'b1011);
        check("t1_busy_c7", switch_busy, 4'b0000);

        run_table(4'b0100);

        // Reselect to channel 3 while the RPi transaction is still in flight
        rpi_cs_n = 1'b0; rpi_sel = 2'd3;
        cyc(10);
        check("t3_owner_held", owner_rpi, 4'b0000);
        check("t3_busy_held", switch_busy, 4'b1100);
        check("t3_memcs_held", mem_cs_n, 4'b1111);
        rpi_cs_n = 1'b1;
        cyc(5);
        check("t3_drainr_d5", switch_busy[2], 1'b1);
        cyc(1);
        check("t3_drainr_d6", switch_busy[2], 1'b0);
        check("t3_owner_d6", owner_rpi, 4'b0000);
        cyc(1);
        check("t3_owner_d7", owner_rpi, 4'b1000);

        // RPi releases channel 3 through DRAIN_R
        rpi_en = 1'b0;
        cyc(3);
        check("t4a_owner_c3", owner_rpi, 4'b0000);
        check("t4a_busy_c3", switch_busy, 4'b1000);
        cyc(3);
        check("t4a_busy_c6", switch_busy[3], 1'b1);
        cyc(1);
        check("t4a_busy_c7", switch_busy, 4'b0000);
        check("t4a_gnt_c7", fpga_gnt, 4'hF);

        // Abandoned request while an engine transaction is in flight
        fpga_cs_n[1] = 1'b0; rpi_en = 1'b1; rpi_sel = 2'd1;
        cyc(4);
        check("t4b_busy_c4", switch_busy, 4'b0010);
        check("t4b_memcs_c4", mem_cs_n[1], 1'b1);
        check("t4b_gnt_c4", fpga_gnt[1], 1'b0);
        rpi_en = 1'b0;
        cyc(2);
        check("t4b_busy_c6", switch_busy[1], 1'b1);
        cyc(1);
        check("t4b_busy_c7", switch_busy[1], 1'b0);
        check("t4b_gnt_c7", fpga_gnt[1], 1'b1);
        check("t4b_memcs_c7", mem_cs_n[1], 1'b0);
        check("t4b_owner_c7", owner_rpi, 4'b0000);
        fpga_cs_n[1] = 1'b1;
        cyc(2);

        // Request arrives during a long engine transaction on channel 1
        fpga_cs_n[1] = 1'b0;
        cyc(5);
        rpi_en = 1'b1; rpi_sel = 2'd1; fpga_sclk[1] = 1'b1;
        cyc(2);
        check("t2_memcs_c7", mem_cs_n[1], 1'b0);
        check("t2_memsclk_c7", mem_sclk[1], 1'b1);
        check("t2_gnt_c7", fpga_gnt[1], 1'b0);
        cyc(1);
        check("t2_memcs_c8", mem_cs_n[1], 1'b1);
        check("t2_memsclk_c8", mem_sclk[1], 1'b0);
        check("t2_busy_c8", switch_busy[1], 1'b1);
        cyc(12);
        fpga_cs_n[1] = 1'b1; fpga_sclk[1] = 1'b0;
        check("t2_owner_c20", owner_rpi, 4'b0000);
        cyc(3);
        check("t2_owner_c23", owner_rpi, 4'b0000);
        cyc(1);
        check("t2_owner_c24", owner_rpi, 4'b0010);

        // Move to channel 2 (waits for channel 1 to drain), then reset mid-transfer
        rpi_sel = 2'd2;
        cyc(7);
        check("t5_owner_c7", owner_rpi, 4'b0000);
        cyc(1);
        check("t5_owner_c8", owner_rpi, 4'b0100);
        rpi_cs_n = 1'b0; mem_miso = 4'b0100;
        cyc(1);
        check("t5_memcs_pre", mem_cs_n[2], 1'b0);
        check("t5_rpimiso_pre", rpi_miso, 1'b1);
        #2 rst = 1'b1;
        #2;
        check("t5_rst_owner", owner_rpi, 4'b0000);
        check("t5_rst_memcs", mem_cs_n, 4'hF);
        check("t5_rst_rpimiso", rpi_miso, 1'b0);
        check("t5_rst_gnt", fpga_gnt, 4'hF);
        check("t5_rst_busy", switch_busy, 4'h0);
        cyc(2);
        rpi_cs_n = 1'b1; mem_miso = 4'h0;
        rst = 1'b0;
        cyc(3);
        check("t5_reacq_busy", switch_busy, 4'b0100);
        check("t5_reacq_owner", owner_rpi, 4'b0000);
        cyc(4);
        check("t5_reacq_owner_c7", owner_rpi, 4'b0100);
        rpi_en = 1'b0;
        cyc(8);

        // 8-channel, one-cycle guard sweep
        for (int k = 0; k < 8; k++) begin
            exp8 = 8'b1 << k;
            e8_en = 1'b1; e8_sel = 3'(k);
            cyc(3);
            check($sformatf("t6_ch%0d_c3", k), e8_owner, 8'h00);
            cyc(1);
            check($sformatf("t6_ch%0d_c4", k), e8_owner, exp8);
            e8_en = 1'b0;
            cyc(5);
            check($sformatf("t6_ch%0d_rel", k), {e8_owner, e8_gnt}, {8'h00, 8'hFF});
        end

        check("exclusive_owner", excl_viol, 0);
        check("sb_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
